bounce_shift_counter: RTL and testbench

//  Parametrised shift-pattern generator: a WIDTH-bit register moved one position per

---
 rtl/bounce_shift_counter.sv | 108 ++++++++++
 tb/tb_bounce_shift_counter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_shift_counter.sv
// Shift-pattern generator: a WIDTH-bit register stepped in bounce, rotate-left,
// rotate-right or hold mode, paced by a prescaler, with load and step/wrap pulses.
module bounce_shift_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    input  logic [WIDTH-1:0] load_pattern,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             wrap
);

    localparam logic [1:0] MODE_BOUNCE = 2'b00;
    localparam logic [1:0] MODE_ROL    = 2'b01;
    localparam logic [1:0] MODE_ROR    = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    logic [DIV_W-1:0] presc;
    logic [DIV_W-1:0] presc_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             dir_nxt;
    logic             step_nxt;
    logic             wrap_nxt;
    logic [WIDTH-1:0] rol_c;
    logic [WIDTH-1:0] ror_c;
    logic             tick_c;

    assign rol_c  = {count[WIDTH-2:0], count[WIDTH-1]};
    assign ror_c  = {count[0], count[WIDTH-1:1]};
    // >= rather than == so that lowering div mid-count ticks on the next cycle
    assign tick_c = en && (mode != MODE_HOLD) && (presc >= div);

    // Next-state: load beats tick; hold mode parks the prescaler at zero
    always_comb begin
        count_nxt = count;
        dir_nxt   = dir;
        presc_nxt = presc;
        step_nxt  = 1'b0;
        wrap_nxt  = 1'b0;
        if (load) begin
            count_nxt = (load_pattern == '0) ? WIDTH'(1) : load_pattern;
            presc_nxt = '0;
        end else if (tick_c) begin
            presc_nxt = '0;
            step_nxt  = 1'b1;
            case (mode)
                MODE_BOUNCE: begin
                    if (!dir) begin
                        if (count[WIDTH-1]) begin
                            dir_nxt   = 1'b1;
                            count_nxt = ror_c;
                            wrap_nxt  = 1'b1;
                        end else begin
                            count_nxt = rol_c;
                        end
                    end else begin
                        if (count[0]) begin
                            dir_nxt   = 1'b0;
                            count_nxt = rol_c;
                            wrap_nxt  = 1'b1;
                        end else begin
                            count_nxt = ror_c;
                        end
                    end
                end
                MODE_ROL: begin
                    count_nxt = rol_c;
                    dir_nxt   = 1'b0;
                    wrap_nxt  = count[WIDTH-1];
                end
                MODE_ROR: begin
                    count_nxt = ror_c;
                    dir_nxt   = 1'b1;
                    wrap_nxt  = count[0];
                end
                default: begin
                    count_nxt = count;
                end
            endcase
        end else if (en) begin
            presc_nxt = (mode == MODE_HOLD) ? '0 : presc + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= WIDTH'(1);
            dir   <= 1'b0;
            presc <= '0;
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            count <= count_nxt;
            dir   <= dir_nxt;
            presc <= presc_nxt;
            step  <= step_nxt;
            wrap  <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_bounce_shift_counter.sv
// Self-checking bench for bounce_shift_counter: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_bounce_shift_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] div;
    logic        load;
    logic [7:0]  load_pattern;
    logic [7:0]  count;
    logic        dir;
    logic        step;
    logic        wrap;

    int checks   = 0;
    int failures = 0;

    bounce_shift_counter #(.WIDTH(8), .DIV_W(16)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .div(div),
        .load(load), .load_pattern(load_pattern),
        .count(count), .dir(dir), .step(step), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [7:0]  m_count;
    logic        m_dir;
    int unsigned m_presc;
    logic        m_step;
    logic        m_wrap;
    bit          model_valid = 1'b0;

    function automatic logic [7:0] rotl(input logic [7:0] v);
        return 8'(((32'(v) * 2) % 256) + (32'(v) / 128));
    endfunction

    function automatic logic [7:0] rotr(input logic [7:0] v);
        return 8'((32'(v) / 2) + ((32'(v) % 2) * 128));
    endfunction

    task automatic model_step();
        bit tick;
        if (reset) begin
            m_count = 8'h01; m_dir = 1'b0; m_presc = 0; m_step = 1'b0; m_wrap = 1'b0;
            model_valid = 1'b1;
        end else if (load) begin
            m_count = (load_pattern == 8'h00) ? 8'h01 : load_pattern;
            m_presc = 0; m_step = 1'b0; m_wrap = 1'b0;
        end else begin
            tick = en && (mode != 2'd3) && (m_presc >= 32'(div));
            m_step = tick;
            m_wrap = 1'b0;
            if (tick) begin
                m_presc = 0;
                if (mode == 2'd1) begin
                    m_wrap = m_count >= 8'h80;
                    m_count = rotl(m_count); m_dir = 1'b0;
                end else if (mode == 2'd2) begin
                    m_wrap = (m_count % 2) == 1;
                    m_count = rotr(m_count); m_dir = 1'b1;
                end else if (!m_dir) begin
                    if (m_count >= 8'h80) begin
                        m_dir = 1'b1; m_wrap = 1'b1; m_count = rotr(m_count);
                    end else m_count = rotl(m_count);
                end else begin
                    if ((m_count % 2) == 1) begin
                        m_dir = 1'b0; m_wrap = 1'b1; m_count = rotl(m_count);
                    end else m_count = rotr(m_count);
                end
            end else if (en) begin
                m_presc = (mode == 2'd3) ? 0 : (m_presc + 1) % 65536;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge; model advances with the DUT and both are compared after the edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        if (model_valid) begin
            chk("model_count", 32'(count), 32'(m_count));
            chk("model_dir",   32'(dir),   32'(m_dir));
            chk("model_step",  32'(step),  32'(m_step));
            chk("model_wrap",  32'(wrap),  32'(m_wrap));
        end
    endtask

    typedef struct {
        logic        r;
        logic        e;
        logic [1:0]  m;
        logic [15:0] d;
        logic        l;
        logic [7:0]  p;
        logic [7:0]  ec;
        logic        ed;
        logic        es;
        logic        ew;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                                input logic [15:0] d, input logic l, input logic [7:0] p,
                                input logic [7:0] ec, input logic ed, input logic es,
                                input logic ew);
        vec_t v;
        v.r = r; v.e = e; v.m = m; v.d = d; v.l = l; v.p = p;
        v.ec = ec; v.ed = ed; v.es = es; v.ew = ew;
        return v;
    endfunction

    task automatic set_in(input logic r, input logic e, input logic [1:0] m,
                          input logic [15:0] d, input logic l, input logic [7:0] p);
        reset = r; en = e; mode = m; div = d; load = l; load_pattern = p;
    endtask

    vec_t vecs[$];

    initial begin
        set_in(1'b1, 1'b0, 2'd0, 16'd0, 1'b0, 8'h00);

        // reset, then full bounce cycle at div=0
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h02, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h04, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h08, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h10, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h20, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h40, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h80, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h40, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h20, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h10, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h08, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h04, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h02, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h01, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'h02, 0, 1, 1));
        // load beats a coincident tick; zero load becomes 01; bounce from 81
        vecs.push_back(mk(0, 1, 0, 0, 1, 8'hA5, 8'hA5, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 8'h00, 8'h01, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 8'h81, 8'h81, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h00, 8'hC0, 1, 1, 1));
        // rotate-left 80 -> 01 wraps, rotate-right 01 -> 80 wraps
        vecs.push_back(mk(0, 1, 1, 0, 1, 8'h80, 8'h80, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 8'h00, 8'h01, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 8'h00, 8'h02, 0, 1, 0));
        vecs.push_back(mk(0, 1, 2, 0, 1, 8'h01, 8'h01, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 0, 0, 8'h00, 8'h80, 1, 1, 1));
        vecs.push_back(mk(0, 1, 2, 0, 0, 8'h00, 8'h40, 1, 1, 0));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].r, vecs[i].e, vecs[i].m, vecs[i].d, vecs[i].l, vecs[i].p);
            cycle();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].ec));
            chk($sformatf("vec%0d_dir", i),   32'(dir),   32'(vecs[i].ed));
            chk($sformatf("vec%0d_step", i),  32'(step),  32'(vecs[i].es));
            chk($sformatf("vec%0d_wrap", i),  32'(wrap),  32'(vecs[i].ew));
        end

        // div=2 pacing and en=0 freeze keeping phase
        set_in(1'b1, 1'b1, 2'd0, 16'd2, 1'b0, 8'h00); cycle();
        set_in(1'b0, 1'b1, 2'd0, 16'd2, 1'b0, 8'h00);
        cycle(); chk("div2_e1_count", 32'(count), 32'h01);
        cycle(); chk("div2_e2_step", 32'(step), 32'h0);
        cycle(); chk("div2_e3_count", 32'(count), 32'h02); chk("div2_e3_step", 32'(step), 32'h1);
        cycle(); chk("div2_e4_step", 32'(step), 32'h0);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("freeze_count", 32'(count), 32'h02);
            chk("freeze_step", 32'(step), 32'h0);
        end
        en = 1'b1;
        cycle(); chk("resume_e1_count", 32'(count), 32'h02);
        cycle(); chk("resume_e2_count", 32'(count), 32'h04); chk("resume_e2_step", 32'(step), 32'h1);

        // reset mid-sequence at count=20, dir=1, presc=1
        set_in(1'b0, 1'b1, 2'd2, 16'd1, 1'b1, 8'h40); cycle();
        load = 1'b0;
        cycle(); cycle();
        chk("pre_rst_count", 32'(count), 32'h20); chk("pre_rst_dir", 32'(dir), 32'h1);
        cycle();
        reset = 1'b1; cycle();
        chk("rst_count", 32'(count), 32'h01); chk("rst_dir", 32'(dir), 32'h0);
        chk("rst_step", 32'(step), 32'h0);    chk("rst_wrap", 32'(wrap), 32'h0);

        // hold for 10 cycles, then bounce with dir=1 at 10
        set_in(1'b0, 1'b1, 2'd2, 16'd0, 1'b1, 8'h20); cycle();
        load = 1'b0; cycle();
        chk("pre_hold_count", 32'(count), 32'h10); chk("pre_hold_dir", 32'(dir), 32'h1);
        mode = 2'd3;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("hold_count", 32'(count), 32'h10);
            chk("hold_step", 32'(step), 32'h0);
        end
        mode = 2'd0; div = 16'd2;
        cycle(); cycle(); chk("unhold_e2_count", 32'(count), 32'h10);
        cycle(); chk("unhold_e3_count", 32'(count), 32'h08); chk("unhold_e3_step", 32'(step), 32'h1);

        // randomized traffic against the model
        reset = 1'b1; cycle();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            load  = ($urandom_range(0, 15) == 0);
            load_pattern = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            en    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) div = 16'($urandom_range(0, 4));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
